// File: rtl/ysyx_25030093_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and FSM state encoding.
package ysyx_25030093_alu_pkg;

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpAnd   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpXor   = 4'd4;
    localparam logic [3:0] OpSll   = 4'd5;
    localparam logic [3:0] OpSrl   = 4'd6;
    localparam logic [3:0] OpSra   = 4'd7;
    localparam logic [3:0] OpSlt   = 4'd8;
    localparam logic [3:0] OpSltu  = 4'd9;
    localparam logic [3:0] OpCsrrw = 4'd10;
    localparam logic [3:0] OpCsrrs = 4'd11;
    localparam logic [3:0] OpCsrrc = 4'd12;
    localparam logic [3:0] OpMul   = 4'd13;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StDone = 2'd2;

endpackage

// File: rtl/ysyx_25030093_alu_mc_if.sv
// Request/result bus of the multi-cycle ALU; master drives requests, slave is the ALU.
interface ysyx_25030093_alu_mc_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_data1;
    logic [XLEN-1:0] alu_data2;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_nowr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_we;

    modport master (
        output in_valid, alu_op, alu_data1, alu_data2, csr_rdata, csr_nowr, flush, out_ready,
        input  in_ready, out_valid, rd_data, csr_wdata, csr_we
    );

    modport slave (
        input  in_valid, alu_op, alu_data1, alu_data2, csr_rdata, csr_nowr, flush, out_ready,
        output in_ready, out_valid, rd_data, csr_wdata, csr_we
    );

endinterface

// File: rtl/ysyx_25030093_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle; returns the low XLEN bits of a * b.
module ysyx_25030093_mul_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;

    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;

    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    // done marks the final step; result already includes that step's partial product
    assign done   = (cnt_q == CntW'(1));
    assign result = acc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (kill) begin
            cnt_q    <= '0;
            acc_q    <= '0;
        end else if (start) begin
            cnt_q    <= CntW'(XLEN);
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
        end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - CntW'(1);
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/ysyx_25030093_alu_mc.sv
// Multi-cycle ALU with CSR support: single-cycle ops finish in one cycle, MUL iterates XLEN cycles.
module ysyx_25030093_alu_mc
    import ysyx_25030093_alu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input logic                   clk,
    input logic                   reset_n,
    ysyx_25030093_alu_mc_if.slave bus
);

    localparam int unsigned ShW = $clog2(XLEN);

    state_t          state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic            we_q, we_d;

    logic [XLEN-1:0] a, b, csr;
    logic [XLEN-1:0] res_rd, res_wd;
    logic            res_we;
    logic [ShW-1:0]  shamt;
    logic            accept, is_mul;
    logic            mul_done;
    logic [XLEN-1:0] mul_res;

    assign a     = bus.alu_data1;
    assign b     = bus.alu_data2;
    assign csr   = bus.csr_rdata;
    assign shamt = b[ShW-1:0];

    assign bus.in_ready  = !bus.flush &&
                           ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    assign bus.out_valid = (state_q == StDone) && !bus.flush;
    assign bus.rd_data   = rd_q;
    assign bus.csr_wdata = wd_q;
    assign bus.csr_we    = we_q && bus.out_valid;

    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = MUL_EN && (bus.alu_op == OpMul);

    // MUL is absent here on purpose: it yields zero unless the iterative unit takes over
    always_comb begin
        res_rd = '0;
        res_wd = '0;
        res_we = 1'b0;
        case (bus.alu_op)
            OpAdd:   res_rd = a + b;
            OpSub:   res_rd = a - b;
            OpAnd:   res_rd = a & b;
            OpOr:    res_rd = a | b;
            OpXor:   res_rd = a ^ b;
            OpSll:   res_rd = a << shamt;
            OpSrl:   res_rd = a >> shamt;
            OpSra:   res_rd = $unsigned($signed(a) >>> shamt);
            OpSlt:   res_rd = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OpSltu:  res_rd = {{(XLEN-1){1'b0}}, a < b};
            OpCsrrw: begin
                res_rd = csr;
                res_wd = a;
                res_we = 1'b1;
            end
            OpCsrrs: begin
                res_rd = csr;
                res_wd = csr | a;
                res_we = !bus.csr_nowr;
            end
            OpCsrrc: begin
                res_rd = csr;
                res_wd = csr & ~a;
                res_we = !bus.csr_nowr;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wd_d    = wd_q;
        we_d    = we_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else if (accept) begin
            state_d = is_mul ? StBusy : StDone;
            rd_d    = res_rd;
            wd_d    = res_wd;
            we_d    = res_we;
        end else begin
            case (state_q)
                StBusy: if (mul_done) begin
                    state_d = StDone;
                    rd_d    = mul_res;
                end
                StDone: if (bus.out_ready) state_d = StIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rd_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
        end
    end

    if (MUL_EN) begin : g_mul
        ysyx_25030093_mul_iter #(
            .XLEN(XLEN)
        ) u_mul (
            .clk    (clk),
            .reset_n(reset_n),
            .start  (accept && is_mul),
            .kill   (bus.flush),
            .a      (a),
            .b      (b),
            .done   (mul_done),
            .result (mul_res)
        );
    end else begin : g_no_mul
        assign mul_done = 1'b0;
        assign mul_res  = '0;
    end

endmodule

// File: tb/tb_ysyx_25030093_alu_mc.sv
// Scoreboard bench for the multi-cycle ALU: expectations queued at accept, checked on result handshake.
module tb_ysyx_25030093_alu_mc;
    import ysyx_25030093_alu_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] rd;
        logic [31:0] wd;
        logic        we;
        logic        chk_wd;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    ysyx_25030093_alu_mc_if #(.XLEN(32)) bus ();

    ysyx_25030093_alu_mc #(
        .XLEN  (32),
        .MUL_EN(1'b1)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] csr, input logic nowr);
        exp_t e;
        logic [63:0] p;
        e = '0;
        e.op = op;
        case (op)
            OpAdd:  e.rd = a + b;
            OpSub:  e.rd = a + ~b + 32'd1;
            OpAnd:  e.rd = a & b;
            OpOr:   e.rd = a | b;
            OpXor:  e.rd = a ^ b;
            OpSll:  e.rd = a << b[4:0];
            OpSrl:  e.rd = a >> b[4:0];
            OpSra:  e.rd = (a >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0);
            OpSlt:  e.rd = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            OpSltu: e.rd = {31'd0, a < b};
            OpCsrrw: begin e.rd = csr; e.wd = a;        e.we = 1'b1;  e.chk_wd = 1'b1; end
            OpCsrrs: begin e.rd = csr; e.wd = csr | a;  e.we = !nowr; e.chk_wd = 1'b1; end
            OpCsrrc: begin e.rd = csr; e.wd = csr & ~a; e.we = !nowr; e.chk_wd = 1'b1; end
            OpMul: begin
                p = {32'd0, a} * {32'd0, b};
                e.rd = p[31:0];
            end
            default: e.rd = 32'd0;
        endcase
        return e;
    endfunction

    // One negedge observation; pops and compares whenever a result is handed over.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("rd op%0d", e.op), bus.rd_data, e.rd);
                if (e.chk_wd) check($sformatf("csr_wdata op%0d", e.op), bus.csr_wdata, e.wd);
                check($sformatf("csr_we op%0d", e.op), bus.csr_we, e.we);
            end
        end
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.alu_op    = 4'($urandom);
        bus.alu_data1 = $urandom;
        bus.alu_data2 = $urandom;
        bus.csr_rdata = $urandom;
        bus.csr_nowr  = 1'($urandom);
    endtask

    // Present a request until accepted; returns the cycle index of the accept cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] csr, input logic nowr, input bit push,
                         output int t_acc);
        bit ok = 0;
        t_acc = -1000;
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.alu_data1 = a;
        bus.alu_data2 = b;
        bus.csr_rdata = csr;
        bus.csr_nowr  = nowr;
        for (int i = 0; i < 100 && !ok; i++) begin
            sample();
            if (bus.in_ready) begin
                ok = 1;
                t_acc = cyc;
                if (push) sb.push_back(model(op, a, b, csr, nowr));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_out(input int t_acc, input int lat, input string tag, output int rdy_busy);
        bit ok = 0;
        rdy_busy = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            sample();
            if (bus.out_valid) begin
                ok = 1;
            end else begin
                if (bus.in_ready) rdy_busy++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
        else check({tag, "_latency"}, cyc - t_acc, lat);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] csr, input logic nowr, input string tag);
        int t, rb;
        issue(op, a, b, csr, nowr, 1, t);
        wait_out(t, (op == OpMul) ? 33 : 1, tag, rb);
        if (op == OpMul) check({tag, "_ready_in_busy"}, rb, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic watch_quiet(input string tag);
        int seen = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (bus.out_valid) seen++;
        end
        check(tag, seen, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t, rb;
        exp_t e;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        scramble();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_csr_we", bus.csr_we, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_csr_wdata", bus.csr_wdata, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sample();
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        run_op(OpAdd, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, "add_ovf");
        run_op(OpSra, 32'h8000_0000, 32'd4, 32'h0, 1'b0, "sra");
        run_op(OpSlt, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, "slt");
        run_op(OpSltu, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, "sltu");
        run_op(OpSub, 32'h0, 32'h1, 32'h0, 1'b0, "sub_wrap");
        run_op(OpSll, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, "sll31");
        run_op(OpSrl, 32'hF000_0000, 32'h0000_0024, 32'h0, 1'b0, "srl_hibits");
        run_op(OpXor, 32'hA5A5_5A5A, 32'hFFFF_0000, 32'h0, 1'b0, "xor");
        run_op(OpCsrrc, 32'h0F, 32'h0, 32'hFF, 1'b0, "csrrc");
        run_op(OpCsrrc, 32'h0F, 32'h0, 32'hFF, 1'b1, "csrrc_nowr");
        run_op(OpCsrrw, 32'h1234_5678, 32'h0, 32'hCAFE_0000, 1'b1, "csrrw");
        run_op(OpCsrrs, 32'h0000_00F0, 32'h0, 32'h0000_000F, 1'b0, "csrrs");
        run_op(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF, 1'b0, "illegal");
        run_op(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, "mul_ff");
        run_op(OpMul, 32'd12345, 32'd6789, 32'h0, 1'b0, "mul_small");

        // Flush in the 10th BUSY cycle, with a competing request in the same cycle
        issue(OpMul, 32'd7, 32'd9, 32'h0, 1'b0, 0, t);
        repeat (9) step();
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_op   = OpAdd;
        sample();
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        sample();
        check("post_flush_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        watch_quiet("flush_no_out");

        // Reset pulse in the middle of a MUL
        issue(OpMul, 32'd3, 32'd5, 32'h0, 1'b0, 0, t);
        repeat (5) step();
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sample();
        check("rst_mid_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        watch_quiet("rst_no_out");

        // Hold the result for 5 cycles, then accept a new request on the result handshake
        bus.out_ready = 1'b0;
        issue(OpCsrrw, 32'hDEAD_BEEF, 32'h0, 32'h0BAD_F00D, 1'b0, 1, t);
        wait_out(t, 1, "stall_first", rb);
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("stall_rd_%0d", i), bus.rd_data, e.rd);
            check($sformatf("stall_wd_%0d", i), bus.csr_wdata, e.wd);
            check($sformatf("stall_we_%0d", i), bus.csr_we, 1);
            check($sformatf("stall_in_ready_%0d", i), bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        issue(OpOr, 32'h0000_F000, 32'h0000_000F, 32'h0, 1'b0, 1, t);
        check("b2b_drained_first", sb.size(), 1);
        wait_out(t, 1, "b2b", rb);
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            logic [3:0] op;
            op = (i % 5 == 4) ? OpMul : 4'($urandom_range(0, 15));
            run_op(op, $urandom, $urandom, $urandom, 1'($urandom), $sformatf("rand%0d", i));
        end

        repeat (3) step();
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
